// File: rtl/fpmult_round_arbiter.sv
// Two-lane front end for a shared FPMult_RoundModule.
// Each lane has a one-entry holding register with a registered ready. A
// round-robin arbiter moves one lane per cycle into the issue register that
// drives the combinational rounder. The rounded result lands in a
// backpressured output register tagged with its source lane and ID.
module fpmult_round_arbiter #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // lane A
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [22:0]     a_m,
  input  logic [8:0]      a_e,
  input  logic [2:0]      a_grs,
  input  logic [ID_W-1:0] a_id,
  // lane B
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [22:0]     b_m,
  input  logic [8:0]      b_e,
  input  logic [2:0]      b_grs,
  input  logic [ID_W-1:0] b_id,
  // to / from the shared rounder
  output logic [22:0]     rm_m,
  output logic [8:0]      rm_e,
  output logic            rm_g,
  output logic            rm_r,
  output logic            rm_s,
  input  logic [22:0]     rm_round_m,
  input  logic [8:0]      rm_round_e,
  // result
  output logic            out_valid,
  input  logic            out_ready,
  output logic [22:0]     out_m,
  output logic [8:0]      out_e,
  output logic            out_ovf,
  output logic            out_src,
  output logic [ID_W-1:0] out_id
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } issState_t;

  // Lane holding registers
  logic            aFull, bFull;
  logic [22:0]     aM, bM;
  logic [8:0]      aE, bE;
  logic [2:0]      aGrs, bGrs;
  logic [ID_W-1:0] aId, bId;

  // Issue stage
  issState_t       issState;
  logic            issSrc;
  logic [ID_W-1:0] issId;
  logic            lastGrant;   // 0 = A, 1 = B

  logic            adv;
  logic            grantA, grantB;

  // Ready comes straight from a flop, so there is no valid-to-ready path.
  assign a_ready = ~aFull;
  assign b_ready = ~bFull;

  // The issue register may move when it is empty, or when its result has
  // somewhere to go (output empty or draining this cycle).
  assign adv = (issState == IDLE) || !out_valid || out_ready;

  // Round-robin grant: a lone full lane wins, on contention the lane that
  // did not win last time goes first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    grantA = 1'b0;
    grantB = 1'b0;
    if (adv) begin
      if (aFull && (!bFull || lastGrant)) grantA = 1'b1;
      else if (bFull)                     grantB = 1'b1;
    end
  end

  // Lane A holding register: fill on handshake, free on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the holding data is reset as well; it is cheap here and keeps the
    // whole block at a known value after reset.
    if (!rst_n) begin
      aFull <= 1'b0;
      aM    <= '0;
      aE    <= '0;
      aGrs  <= '0;
      aId   <= '0;
    end else if (a_valid && !aFull) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of block ordering.
      aFull <= 1'b1;
      aM    <= a_m;
      aE    <= a_e;
      aGrs  <= a_grs;
      aId   <= a_id;
    end else if (grantA) begin
      aFull <= 1'b0;
    end
  end

  // Lane B holding register: fill on handshake, free on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bFull <= 1'b0;
      bM    <= '0;
      bE    <= '0;
      bGrs  <= '0;
      bId   <= '0;
    end else if (b_valid && !bFull) begin
      bFull <= 1'b1;
      bM    <= b_m;
      bE    <= b_e;
      bGrs  <= b_grs;
      bId   <= b_id;
    end else if (grantB) begin
      bFull <= 1'b0;
    end
  end

  // Issue stage FSM: load the granted lane, hold rm_* while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issState  <= IDLE;
      issSrc    <= 1'b0;
      issId     <= '0;
      lastGrant <= 1'b1;       // B, so A wins the first contention
      rm_m      <= '0;
      rm_e      <= '0;
      rm_g      <= 1'b0;
      rm_r      <= 1'b0;
      rm_s      <= 1'b0;
    end else if (adv) begin
      if (grantA) begin
        issState            <= BUSY;
        issSrc              <= 1'b0;
        issId               <= aId;
        lastGrant           <= 1'b0;
        rm_m                <= aM;
        rm_e                <= aE;
        {rm_g, rm_r, rm_s}  <= aGrs;
      end else if (grantB) begin
        issState            <= BUSY;
        issSrc              <= 1'b1;
        issId               <= bId;
        lastGrant           <= 1'b1;
        rm_m                <= bM;
        rm_e                <= bE;
        {rm_g, rm_r, rm_s}  <= bGrs;
      end else begin
        issState <= IDLE;
      end
    end
  end

  // Output register: capture the rounder result, drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_m     <= '0;
      out_e     <= '0;
      out_ovf   <= 1'b0;
      out_src   <= 1'b0;
      out_id    <= '0;
    end else if (adv && (issState == BUSY)) begin
      out_valid <= 1'b1;
      out_m     <= rm_round_m;
      out_e     <= rm_round_e;
      out_ovf   <= rm_round_e[8];
      out_src   <= issSrc;
      out_id    <= issId;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpmult_round_arbiter.sv
// Bench for fpmult_round_arbiter: a behavioural rounder closes the rm_* loop,
// per-lane scoreboard queues hold the expected results, directed sequences
// cover latency, arbitration order, backpressure, overflow and reset.
module tb_fpmult_round_arbiter;

  localparam int ID_W = 4;

  typedef struct packed {
    logic [22:0]     m;
    logic [8:0]      e;
    logic            ovf;
    logic [ID_W-1:0] id;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic            a_ready, b_ready;
  logic [22:0]     a_m = '0, b_m = '0;
  logic [8:0]      a_e = '0, b_e = '0;
  logic [2:0]      a_grs = '0, b_grs = '0;
  logic [ID_W-1:0] a_id = '0, b_id = '0;
  logic [22:0]     rm_m;
  logic [8:0]      rm_e;
  logic            rm_g, rm_r, rm_s;
  logic [22:0]     rm_round_m;
  logic [8:0]      rm_round_e;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [22:0]     out_m;
  logic [8:0]      out_e;
  logic            out_ovf, out_src;
  logic [ID_W-1:0] out_id;

  int nVectors = 0;
  int nMiscompares = 0;
  int cycleCnt = 0;

  exp_t qA[$];
  exp_t qB[$];
  logic srcLog[$];
  int   stampLog[$];

  fpmult_round_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_m(a_m), .a_e(a_e), .a_grs(a_grs), .a_id(a_id),
    .b_valid(b_valid), .b_ready(b_ready), .b_m(b_m), .b_e(b_e), .b_grs(b_grs), .b_id(b_id),
    .rm_m(rm_m), .rm_e(rm_e), .rm_g(rm_g), .rm_r(rm_r), .rm_s(rm_s),
    .rm_round_m(rm_round_m), .rm_round_e(rm_round_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_m(out_m), .out_e(out_e),
    .out_ovf(out_ovf), .out_src(out_src), .out_id(out_id)
  );

  always #5 clk = ~clk;

  // Round-to-nearest-even rounder model; returns {RoundE, RoundM}.
  function automatic logic [31:0] roundModel(input logic [22:0] m, input logic [8:0] e,
                                             input logic [2:0] grs);
    logic        up;
    logic [22:0] upM;
    up  = grs[2] & (grs[1] | grs[0] | m[0]);
    upM = m + 23'd1;
    if (up) return {((upM == 23'd0) ? e + 9'd1 : e), upM};
    return {e, m};
  endfunction

  always_comb {rm_round_e, rm_round_m} = roundModel(rm_m, rm_e, {rm_g, rm_r, rm_s});

  function automatic exp_t mkExp(input logic [22:0] m, input logic [8:0] e,
                                 input logic [2:0] grs, input logic [ID_W-1:0] id);
    logic [31:0] r;
    exp_t x;
    r     = roundModel(m, e, grs);
    x.m   = r[22:0];
    x.e   = r[31:23];
    x.ovf = r[31];
    x.id  = id;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nVectors++;
    if (got !== want) begin
      nMiscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t x;
    cycleCnt++;
    if (!rst_n) begin
      qA.delete();
      qB.delete();
    end else begin
      if (a_valid && a_ready) qA.push_back(mkExp(a_m, a_e, a_grs, a_id));
      if (b_valid && b_ready) qB.push_back(mkExp(b_m, b_e, b_grs, b_id));
      if (out_valid && out_ready) begin
        if ((out_src ? qB.size() : qA.size()) == 0) begin
          check("unexpected_output", 32'(out_src), 32'(2));
        end else begin
          x = out_src ? qB.pop_front() : qA.pop_front();
          check("sb_out_m",   32'(out_m),   32'(x.m));
          check("sb_out_e",   32'(out_e),   32'(x.e));
          check("sb_out_ovf", 32'(out_ovf), 32'(x.ovf));
          check("sb_out_id",  32'(out_id),  32'(x.id));
        end
        srcLog.push_back(out_src);
        stampLog.push_back(cycleCnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    srcLog.delete();
    stampLog.delete();
  endtask

  // Drive both lanes with random operands until nA / nB are accepted.
  task automatic runLanes(input int nA, input int nB, input int budget);
    int sentA = 0, sentB = 0, cyc = 0;
    logic fa, fb;
    logic [31:0] r;
    a_id = '0;
    b_id = '0;
    r = $urandom; a_m = r[22:0]; a_e = r[31:23]; r = $urandom; a_grs = r[2:0];
    r = $urandom; b_m = r[22:0]; b_e = r[31:23]; r = $urandom; b_grs = r[2:0];
    a_valid = (nA > 0);
    b_valid = (nB > 0);
    while ((sentA < nA || sentB < nB) && cyc < budget) begin
      @(negedge clk);
      fa = a_valid & a_ready;
      fb = b_valid & b_ready;
      tick();
      cyc++;
      if (fa) begin
        sentA++;
        a_id++;
        r = $urandom; a_m = r[22:0]; a_e = r[31:23]; r = $urandom; a_grs = r[2:0];
        a_valid = (sentA < nA);
      end
      if (fb) begin
        sentB++;
        b_id++;
        r = $urandom; b_m = r[22:0]; b_e = r[31:23]; r = $urandom; b_grs = r[2:0];
        b_valid = (sentB < nB);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("lanes_sent_a", 32'(sentA), 32'(nA));
    check("lanes_sent_b", 32'(sentB), 32'(nB));
  endtask

  task automatic waitDrain(input int budget);
    int cyc = 0;
    while ((qA.size() != 0 || qB.size() != 0 || out_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("drain_timeout", 32'(cyc < budget), 32'(1));
  endtask

  // Single A op from an idle block; checks the two-edge latency.
  task automatic latencyA(input logic [22:0] m, input logic [8:0] e,
                          input logic [2:0] grs, input logic [ID_W-1:0] id);
    exp_t x;
    x = mkExp(m, e, grs, id);
    check("lat_a_ready_pre", 32'(a_ready), 32'(1));
    a_m = m; a_e = e; a_grs = grs; a_id = id; a_valid = 1'b1;
    tick();                                   // edge k: accepted
    a_valid = 1'b0;
    check("lat_a_ready_full", 32'(a_ready), 32'(0));
    check("lat_valid_k",      32'(out_valid), 32'(0));
    tick();                                   // edge k+1: issued
    check("lat_valid_k1", 32'(out_valid), 32'(0));
    check("lat_rm_m",     32'(rm_m), 32'(m));
    check("lat_rm_e",     32'(rm_e), 32'(e));
    tick();                                   // edge k+2: result
    check("lat_valid_k2", 32'(out_valid), 32'(1));
    check("lat_out_src",  32'(out_src), 32'(0));
    check("lat_out_id",   32'(out_id), 32'(id));
    check("lat_out_m",    32'(out_m), 32'(x.m));
    check("lat_out_e",    32'(out_e), 32'(x.e));
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] snapM;
    logic [ID_W-1:0] snapId;

    // Reset state
    #3;
    check("rst_a_ready",   32'(a_ready), 32'(1));
    check("rst_b_ready",   32'(b_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_m",     32'(out_m), 32'(0));
    check("rst_out_id",    32'(out_id), 32'(0));
    check("rst_rm_m",      32'(rm_m), 32'(0));
    check("rst_rm_e",      32'(rm_e), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single A op with latency check
    latencyA(23'h400000, 9'h080, 3'b000, 4'd3);
    check("t1_out_m_const", 32'(out_m), 32'h400000);
    check("t1_out_e_const", 32'(out_e), 32'h080);
    waitDrain(20);

    // Both lanes streaming: strict A/B alternation, one result per cycle
    resetPulse();
    clearLogs();
    runLanes(8, 8, 100);
    waitDrain(50);
    check("alt_count", 32'(srcLog.size()), 32'(16));
    for (int i = 0; i < srcLog.size(); i++) begin
      check("alt_src", 32'(srcLog[i]), 32'(i % 2));
      if (i > 0) check("alt_gap", 32'(stampLog[i] - stampLog[i-1]), 32'(1));
    end

    // Backpressure: fill every stage, stall five cycles, then release
    clearLogs();
    out_ready = 1'b0;
    runLanes(2, 2, 30);
    tick();
    snapM  = out_m;
    snapId = out_id;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",   32'(out_valid), 32'(1));
      check("bp_m_stable",  32'(out_m), 32'(snapM));
      check("bp_id_stable", 32'(out_id), 32'(snapId));
      check("bp_a_ready", 32'(a_ready), 32'(0));
      check("bp_b_ready", 32'(b_ready), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    waitDrain(30);
    check("bp_count", 32'(srcLog.size()), 32'(4));
    for (int i = 1; i < stampLog.size(); i++)
      check("bp_gap", 32'(stampLog[i] - stampLog[i-1]), 32'(1));

    // Rounding carry into exponent bit 8
    latencyA(23'h7FFFFF, 9'h0FF, 3'b100, 4'd9);
    check("ovf_flag", 32'(out_ovf), 32'(1));
    check("ovf_e",    32'(out_e), 32'h100);
    check("ovf_m",    32'(out_m), 32'h000000);
    waitDrain(20);

    // Only lane B: ids 0..4 in order, one result every two cycles
    clearLogs();
    runLanes(0, 5, 40);
    waitDrain(30);
    check("bonly_count", 32'(srcLog.size()), 32'(5));
    for (int i = 0; i < srcLog.size(); i++) begin
      check("bonly_src", 32'(srcLog[i]), 32'(1));
      if (i > 0) check("bonly_gap", 32'(stampLog[i] - stampLog[i-1]), 32'(2));
    end

    // Reset with issue and output registers full
    out_ready = 1'b0;
    runLanes(2, 2, 30);
    check("prerst_valid", 32'(out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_a_ready",   32'(a_ready), 32'(1));
    check("midrst_b_ready",   32'(b_ready), 32'(1));
    check("midrst_rm_m",      32'(rm_m), 32'(0));
    out_ready = 1'b1;
    repeat (2) tick();
    check("midrst_hold_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b1;
    tick();
    latencyA(23'h123456, 9'h07F, 3'b110, 4'd5);
    waitDrain(20);

    check("final_qA_empty", 32'(qA.size()), 32'(0));
    check("final_qB_empty", 32'(qB.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fpmult_round_arbiter.md
# fpmult_round_arbiter

Shares one combinational FPMult_RoundModule between two normalisation lanes (A, B) of the DSP48E1 floating-point multiplier. Each lane gets a one-entry holding register and a valid/ready handshake. A round-robin arbiter issues one lane per cycle into a registered issue stage that drives the rounder. Rounded results are captured in a backpressured output register, tagged with source lane and transaction ID.

## Interface
- ID_W, 4, width of the per-transaction tag carried from input to output.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- a_valid / b_valid  in  1  lane has a normalised operand
- a_ready / b_ready  out  1  lane holding register empty; equals ~full
- a_m / b_m  in  23  normalised mantissa (NormM)
- a_e / b_e  in  9  normalised exponent (NormE)
- a_grs / b_grs  in  3  {G,R,S}
- a_id / b_id  in  ID_W  transaction tag
- rm_m  out  23  to rounder NormM (issue register)
- rm_e  out  9  to rounder NormE
- rm_g, rm_r, rm_s  out  1  to rounder G, R, S
- rm_round_m  in  23  from rounder RoundM
- rm_round_e  in  9  from rounder RoundE
- out_valid  out  1  result register full
- out_ready  in  1  downstream accepts
- out_m  out  23  rounded mantissa
- out_e  out  9  rounded exponent
- out_ovf  out  1  rm_round_e[8] captured with the result
- out_src  out  1  0 = lane A, 1 = lane B
- out_id  out  ID_W  tag of the result

## Operation
- Lane hold: on a_valid & a_ready, capture {a_m,a_e,a_grs,a_id} and set a_full. Clear a_full when lane A is issued. Lane B is identical. Ready is registered (~full); no combinational valid→ready path.
- Issue stage states:
  - IDLE: issue register empty.
  - BUSY: issue register holds an operand and drives the rm_* outputs.
- Issue stage advances (adv) when it is empty, or when it is BUSY and the output register is empty or draining (out_valid & out_ready).
- On adv with at least one lane full: load the granted lane into the issue register and go/stay BUSY. On adv with no lane full: go IDLE.
- Arbitration:
  - Single full lane wins.
  - Both full: the lane ≠ last_grant wins.
  - last_grant updates only on an actual grant.
- Output capture: on adv while BUSY, load out_m/out_e from rm_round_m/rm_round_e, out_ovf = rm_round_e[8], plus out_src/out_id from the issue register; set out_valid.
- Output drain: clear out_valid on out_ready when no new capture occurs in the same cycle.
- In IDLE, rm_* outputs hold their last values (no toggling).

## Timing
- Reset (async assert, sync-released use): a_full=b_full=0, so a_ready=b_ready=1. Issue state IDLE. out_valid=0. out_m, out_e, out_ovf, out_src, out_id, and all rm_* = 0. last_grant=B, so A wins the first contention.
- Latency: accept at edge k → issued at edge k+1 → out_valid at edge k+2 (no backpressure).
- Throughput:
  - Per lane, 1 result / 2 cycles, because ready is registered and the lane is freed at issue.
  - Two lanes interleaved give 1 result / cycle.
- Output stall (out_ready=0 with out_valid=1): issue register holds, lane registers hold, ready stays low for full lanes, and no data is lost or duplicated.
- Simultaneous drain and capture in one cycle: out_valid stays 1 with the new data.
- Reset asserted mid-operation discards all in-flight entries immediately, with no output pulse.
- Exponent width: 9 bits throughout; no saturation in this block.

## Test plan
- Single A op, out_ready=1: a_m=23'h400000, a_e=9'h080, grs=3'b000, id=3 at edge 0 → out_valid at edge 2 with out_m/out_e equal to the rounder's outputs, out_src=0, out_id=3.
- Both lanes valid every cycle, out_ready=1 → out_src sequence 0,1,0,1… starting with A after reset. One result per cycle in steady state. IDs preserved in order per lane.
- Backpressure: out_ready=0 for 5 cycles with both lanes loaded → out_valid=1 with data stable, a_ready=b_ready=0 once full. After release, the remaining results emerge on consecutive cycles with no loss or duplication.
- Rounding-carry overflow: operand whose rounder result gives rm_round_e=9'h100 → out_ovf=1, out_e=9'h100.
- Only B active (5 ops, ids 0..4) → all out_src=1, ids 0..4 in order, one result per 2 cycles.
- rst_n pulsed low while issue and output registers are full → out_valid=0 and a_ready=b_ready=1 immediately. The next A op completes with 2-cycle latency.
